// File: rtl/imm_pool.sv
// Immediate-operand pool between dispatch and issue: owns its free list, supports
// branch-tag kill/clear. Define IMMPOOL_ERRCHK_EN to add the sticky protocol error output.
module imm_pool #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 16,
  parameter int SEL_W   = $clog2(DEPTH),
  parameter int NPORT   = 2,
  parameter int BR_TAGS = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORT-1:0]         alloc_req,
  input  logic [NPORT*DATA_W-1:0]  alloc_data,
  input  logic [NPORT*BR_TAGS-1:0] alloc_brmask,
  output logic                     alloc_gnt,
  output logic [NPORT*SEL_W-1:0]   alloc_ptr,
  input  logic [NPORT-1:0]         issue_vld,
  input  logic [NPORT*SEL_W-1:0]   issue_ptr,
  output logic [NPORT*DATA_W-1:0]  issue_data,
  output logic [NPORT-1:0]         issue_data_vld,
  input  logic                     prmiss,
  input  logic [BR_TAGS-1:0]       prmiss_tag,
  input  logic                     brsucc,
  input  logic [BR_TAGS-1:0]       brsucc_tag,
  output logic [SEL_W:0]           free_cnt
`ifdef IMMPOOL_ERRCHK_EN
  ,
  output logic                     err
`endif
);

  logic [DEPTH-1:0]              valid, valid_nxt, taken, iss_clr;
  logic [DEPTH-1:0][DATA_W-1:0]  data;
  logic [DEPTH-1:0][BR_TAGS-1:0] brmask, brmask_nxt;
  logic [SEL_W:0]                req_cnt, free_nxt;
  logic                          found;

  // Port p takes the lowest free entry not already claimed by a lower port.
  always_comb begin
    taken     = '0;
    alloc_ptr = '0;
    req_cnt   = '0;
    found     = 1'b0;
    for (int p = 0; p < NPORT; p++) begin
      if (alloc_req[p]) begin
        req_cnt = req_cnt + (SEL_W+1)'(1);
        found   = 1'b0;
        for (int e = 0; e < DEPTH; e++) begin
          if (!found && !valid[e] && !taken[e]) begin
            found    = 1'b1;
            taken[e] = 1'b1;
            alloc_ptr[p*SEL_W +: SEL_W] = SEL_W'(e);
          end
        end
      end
    end
  end

  // free_cnt tracks the number of invalid entries exactly, so this also
  // guarantees every requesting port found an entry.
  assign alloc_gnt = !prmiss && (free_cnt >= req_cnt);

  always_comb begin
    iss_clr = '0;
    for (int p = 0; p < NPORT; p++)
      if (issue_vld[p]) iss_clr[issue_ptr[p*SEL_W +: SEL_W]] = 1'b1;
  end

  always_comb begin
    valid_nxt  = valid;
    brmask_nxt = brmask;
    free_nxt   = (SEL_W+1)'(DEPTH);
    for (int e = 0; e < DEPTH; e++) begin
      if (prmiss) begin
        if (|(brmask[e] & prmiss_tag)) valid_nxt[e] = 1'b0;
      end else if (brsucc) begin
        brmask_nxt[e] = brmask[e] & ~brsucc_tag;
      end
      if (iss_clr[e]) valid_nxt[e] = 1'b0;
    end
    if (alloc_gnt) begin
      for (int p = 0; p < NPORT; p++) begin
        if (alloc_req[p]) begin
          valid_nxt[alloc_ptr[p*SEL_W +: SEL_W]]  = 1'b1;
          brmask_nxt[alloc_ptr[p*SEL_W +: SEL_W]] = alloc_brmask[p*BR_TAGS +: BR_TAGS] &
                                                    ~(brsucc ? brsucc_tag : '0);
        end
      end
    end
    for (int e = 0; e < DEPTH; e++)
      if (valid_nxt[e]) free_nxt = free_nxt - (SEL_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid          <= '0;
      brmask         <= '0;
      free_cnt       <= (SEL_W+1)'(DEPTH);
      issue_data     <= '0;
      issue_data_vld <= '0;
    end else begin
      valid          <= valid_nxt;
      brmask         <= brmask_nxt;
      free_cnt       <= free_nxt;
      issue_data_vld <= issue_vld;
      for (int p = 0; p < NPORT; p++)
        if (issue_vld[p])
          issue_data[p*DATA_W +: DATA_W] <= data[issue_ptr[p*SEL_W +: SEL_W]];
    end
  end

  // Payload storage carries no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (!reset && alloc_gnt) begin
      for (int p = 0; p < NPORT; p++)
        if (alloc_req[p])
          data[alloc_ptr[p*SEL_W +: SEL_W]] <= alloc_data[p*DATA_W +: DATA_W];
    end
  end

`ifdef IMMPOOL_ERRCHK_EN
  logic err_evt;

  always_comb begin
    err_evt = !prmiss && (|alloc_req) && (free_cnt == '0);
    for (int p = 0; p < NPORT; p++)
      if (issue_vld[p] && !valid[issue_ptr[p*SEL_W +: SEL_W]]) err_evt = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)        err <= 1'b0;
    else if (err_evt) err <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_imm_pool.sv
// Self-checking bench for imm_pool: directed test-plan steps followed by random
// traffic, all checked against an entry-array reference model.
module tb_imm_pool;
  localparam int DW = 32, D = 16, SW = 4, NP = 2, BT = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [NP-1:0]    alloc_req;
  logic [NP*DW-1:0] alloc_data;
  logic [NP*BT-1:0] alloc_brmask;
  logic             alloc_gnt;
  logic [NP*SW-1:0] alloc_ptr;
  logic [NP-1:0]    issue_vld;
  logic [NP*SW-1:0] issue_ptr;
  logic [NP*DW-1:0] issue_data;
  logic [NP-1:0]    issue_data_vld;
  logic             prmiss, brsucc;
  logic [BT-1:0]    prmiss_tag, brsucc_tag;
  logic [SW:0]      free_cnt;
`ifdef IMMPOOL_ERRCHK_EN
  logic             err;
`endif

  always #5 clk = ~clk;

  imm_pool dut (
    .clk(clk), .reset(reset),
    .alloc_req(alloc_req), .alloc_data(alloc_data), .alloc_brmask(alloc_brmask),
    .alloc_gnt(alloc_gnt), .alloc_ptr(alloc_ptr),
    .issue_vld(issue_vld), .issue_ptr(issue_ptr),
    .issue_data(issue_data), .issue_data_vld(issue_data_vld),
    .prmiss(prmiss), .prmiss_tag(prmiss_tag),
    .brsucc(brsucc), .brsucc_tag(brsucc_tag),
    .free_cnt(free_cnt)
`ifdef IMMPOOL_ERRCHK_EN
    ,
    .err(err)
`endif
  );

  // Reference model: one slot per entry.
  logic          mvalid [D];
  logic [DW-1:0] mdata  [D];
  logic [BT-1:0] mmask  [D];
  logic [DW-1:0] exp_id [NP];
  logic          obs_gnt;
  logic [SW-1:0] obs_ptr [NP];
  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic idle();
    alloc_req = '0; alloc_data = '0; alloc_brmask = '0;
    issue_vld = '0; issue_ptr = '0;
    prmiss = 1'b0; prmiss_tag = '0; brsucc = 1'b0; brsucc_tag = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_free_cnt", free_cnt, 64'd16);
    chk("rst_issue_vld", issue_data_vld, 64'd0);
    chk("rst_issue_data", issue_data, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int e = 0; e < D; e++) mvalid[e] = 1'b0;
    for (int p = 0; p < NP; p++) exp_id[p] = '0;
  endtask

  task automatic step(input logic [1:0] req, input logic [31:0] d0, input logic [31:0] d1,
                      input logic [3:0] m0, input logic [3:0] m1,
                      input logic [1:0] iv, input logic [3:0] ip0, input logic [3:0] ip1,
                      input logic pm, input logic [3:0] pt, input logic bs, input logic [3:0] bt);
    int nfree, nreq;
    logic eg, fnd;
    logic [3:0] ep [NP];
    logic tk [D];
    logic [31:0] dd [NP];
    logic [3:0] mm [NP];
    logic [3:0] ipp [NP];
    @(negedge clk);
    alloc_req = req; alloc_data = {d1, d0}; alloc_brmask = {m1, m0};
    issue_vld = iv; issue_ptr = {ip1, ip0};
    prmiss = pm; prmiss_tag = pt; brsucc = bs; brsucc_tag = bt;
    dd[0] = d0; dd[1] = d1; mm[0] = m0; mm[1] = m1; ipp[0] = ip0; ipp[1] = ip1;
    nfree = 0;
    for (int e = 0; e < D; e++) begin
      tk[e] = 1'b0;
      if (!mvalid[e]) nfree++;
    end
    nreq = int'(req[0]) + int'(req[1]);
    eg = (nfree >= nreq) && !pm;
    for (int p = 0; p < NP; p++) begin
      ep[p] = '0;
      fnd = 1'b0;
      if (req[p])
        for (int e = 0; e < D; e++)
          if (!fnd && !mvalid[e] && !tk[e]) begin
            fnd = 1'b1; tk[e] = 1'b1; ep[p] = 4'(e);
          end
    end
    #1;
    obs_gnt = alloc_gnt;
    obs_ptr[0] = alloc_ptr[3:0];
    obs_ptr[1] = alloc_ptr[7:4];
    chk("alloc_gnt", alloc_gnt, eg);
    for (int p = 0; p < NP; p++)
      if (req[p] && eg) chk("alloc_ptr", obs_ptr[p], ep[p]);
    @(posedge clk);
    for (int p = 0; p < NP; p++) if (iv[p]) exp_id[p] = mdata[ipp[p]];
    if (pm) begin
      for (int e = 0; e < D; e++) if (mvalid[e] && (mmask[e] & pt) != 0) mvalid[e] = 1'b0;
    end else if (bs) begin
      for (int e = 0; e < D; e++) mmask[e] = mmask[e] & ~bt;
    end
    for (int p = 0; p < NP; p++) if (iv[p]) mvalid[ipp[p]] = 1'b0;
    if (eg)
      for (int p = 0; p < NP; p++)
        if (req[p]) begin
          mvalid[ep[p]] = 1'b1;
          mdata[ep[p]]  = dd[p];
          mmask[ep[p]]  = mm[p] & ~(bs ? bt : 4'b0);
        end
    #1;
    nfree = 0;
    for (int e = 0; e < D; e++) if (!mvalid[e]) nfree++;
    chk("free_cnt", free_cnt, 64'(nfree));
    chk("issue_data_vld", issue_data_vld, iv);
    for (int p = 0; p < NP; p++)
      if (iv[p]) chk("issue_data", issue_data[p*DW +: DW], exp_id[p]);
  endtask

  task automatic al(input logic [1:0] req, input logic [31:0] d0, input logic [31:0] d1,
                    input logic [3:0] m0, input logic [3:0] m1);
    step(req, d0, d1, m0, m1, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
  endtask

  task automatic is(input logic [1:0] iv, input logic [3:0] p0, input logic [3:0] p1);
    step(2'b00, 32'd0, 32'd0, 4'd0, 4'd0, iv, p0, p1, 1'b0, 4'd0, 1'b0, 4'd0);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    do_reset();

    // basic alloc of two ports, then issue both
    al(2'b11, 32'h11, 32'h22, 4'd0, 4'd0);
    chk("t1_gnt", obs_gnt, 64'd1);
    chk("t1_ptr0", obs_ptr[0], 64'd0);
    chk("t1_ptr1", obs_ptr[1], 64'd1);
    chk("t1_free", free_cnt, 64'd14);
    is(2'b11, 4'd0, 4'd1);
    chk("t1_data0", issue_data[31:0], 64'h11);
    chk("t1_data1", issue_data[63:32], 64'h22);
    chk("t1_free_after", free_cnt, 64'd16);

    // fill to one free entry, then over-request
    for (int i = 0; i < 7; i++) al(2'b11, 32'h100 + 32'(2*i), 32'h101 + 32'(2*i), 4'd0, 4'd0);
    al(2'b01, 32'h200, 32'd0, 4'd0, 4'd0);
    chk("t2_free1", free_cnt, 64'd1);
    al(2'b11, 32'h1, 32'h2, 4'd0, 4'd0);
    chk("t2_full_gnt", obs_gnt, 64'd0);
    chk("t2_full_free", free_cnt, 64'd1);
    al(2'b01, 32'h300, 32'd0, 4'd0, 4'd0);
    chk("t2_last_gnt", obs_gnt, 64'd1);
    chk("t2_last_ptr", obs_ptr[0], 64'd15);
    chk("t2_empty", free_cnt, 64'd0);

    // no same-cycle reuse of an issued entry
    is(2'b01, 4'd7, 4'd0);
    step(2'b01, 32'h55, 32'd0, 4'd0, 4'd0, 2'b01, 4'd3, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0);
    chk("t5_not3", obs_ptr[0], 64'd7);
    al(2'b01, 32'h66, 32'd0, 4'd0, 4'd0);
    chk("t5_reuse3", obs_ptr[0], 64'd3);
    for (int i = 0; i < 8; i++) is(2'b11, 4'(2*i), 4'(2*i+1));
    chk("drain_free", free_cnt, 64'd16);

    // selective kill on mispredict, concurrent alloc refused
    al(2'b11, 32'hAA, 32'hBB, 4'b0010, 4'b0000);
    step(2'b01, 32'hCC, 32'd0, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 1'b1, 4'b0010, 1'b0, 4'd0);
    chk("t3_gnt", obs_gnt, 64'd0);
    chk("t3_free", free_cnt, 64'd15);
    is(2'b01, 4'd1, 4'd0);
    chk("t3_data", issue_data[31:0], 64'hBB);

    // tag cleared at alloc survives later mispredict of that tag
    step(2'b01, 32'hDD, 32'd0, 4'b0100, 4'd0, 2'b00, 4'd0, 4'd0, 1'b0, 4'd0, 1'b1, 4'b0100);
    step(2'b00, 32'd0, 32'd0, 4'd0, 4'd0, 2'b00, 4'd0, 4'd0, 1'b1, 4'b0100, 1'b0, 4'd0);
    chk("t4_survive", free_cnt, 64'd15);
    is(2'b01, 4'd0, 4'd0);
    chk("t4_data", issue_data[31:0], 64'hDD);

    // both ports issue the same entry
    al(2'b01, 32'hEE, 32'd0, 4'd0, 4'd0);
    is(2'b11, 4'd0, 4'd0);
    chk("dup_data1", issue_data[63:32], 64'hEE);
    chk("dup_free", free_cnt, 64'd16);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [1:0] iv;
      logic [3:0] ip [NP];
      int vl [$];
      vl = {};
      for (int e = 0; e < D; e++) if (mvalid[e]) vl.push_back(e);
      iv = '0; ip[0] = '0; ip[1] = '0;
      for (int p = 0; p < NP; p++)
        if (vl.size() > 0 && $urandom_range(0, 1) == 1) begin
          iv[p] = 1'b1;
          ip[p] = 4'(vl[$urandom_range(0, vl.size() - 1)]);
        end
      step(2'($urandom), $urandom, $urandom, 4'($urandom), 4'($urandom), iv, ip[0], ip[1],
           $urandom_range(0, 7) == 0, 4'(1 << $urandom_range(0, 3)),
           $urandom_range(0, 3) == 0, 4'(1 << $urandom_range(0, 3)));
    end

`ifdef IMMPOOL_ERRCHK_EN
    do_reset();
    chk("err_rst", err, 64'd0);
    @(negedge clk);
    issue_vld = 2'b01; issue_ptr = 8'h05;
    @(posedge clk);
    #1;
    chk("err_set", err, 64'd1);
    @(negedge clk);
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("err_sticky", err, 64'd1);
    do_reset();
    chk("err_clear", err, 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
